// File: rtl/trdb_pkg.sv
// Shared types and constants for the trace encapsulator.
// Header byte layout: bit 7 = lost, bits 6:5 = flow, bits 4:0 = payload length.
package trdb_pkg;

  localparam int ENC_LEN_W    = 5;
  localparam int ENC_FLOW_W   = 2;
  localparam int HDR_LEN_LSB  = 0;
  localparam int HDR_FLOW_LSB = 5;
  localparam int HDR_LOST_BIT = 7;

  typedef enum logic [1:0] {
    HDR = 2'd0,
    TS  = 2'd1,
    PAY = 2'd2
  } trdb_encap_state_e;

  // Assemble the packet header byte from its fields.
  function automatic logic [7:0] make_header(input logic                  lost,
                                             input logic [ENC_FLOW_W-1:0] flow,
                                             input logic [ENC_LEN_W-1:0]  len);
    logic [7:0] h;
    h                              = '0;
    h[HDR_LOST_BIT]                = lost;
    h[HDR_FLOW_LSB +: ENC_FLOW_W]  = flow;
    h[HDR_LEN_LSB  +: ENC_LEN_W]   = len;
    return h;
  endfunction

endpackage

// File: rtl/trdb_encap_fifo.sv
// Synchronous packet FIFO. A push while full is accepted only when a pop
// happens in the same cycle, so the occupancy stays unchanged.
module trdb_encap_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/trdb_encapsulator.sv
// Packet-to-byte-stream encapsulator: buffers packets from the emitter and
// serialises header, optional timestamp and payload bytes (LSB-first).
// Optional feature macro: TRDB_TIMESTAMP_EN (adds time_i and TS bytes).
//
// Output handshake: a byte transfers in a cycle where byte_valid_o && byte_ready_i.
// Once byte_valid_o is high, byte_o/last_o stay stable until that transfer.
module trdb_encapsulator import trdb_pkg::*; #(
  parameter int PAYLOAD_BYTES = 16,
  parameter int FIFO_DEPTH    = 4,
  parameter int TS_BYTES      = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       valid_i,
  input  logic [PAYLOAD_BYTES*8-1:0] payload_i,
  input  logic [ENC_LEN_W-1:0]       length_i,
  input  logic [ENC_FLOW_W-1:0]      flow_i,
`ifdef TRDB_TIMESTAMP_EN
  input  logic [TS_BYTES*8-1:0]      time_i,
`endif
  output logic [7:0]                 byte_o,
  output logic                       byte_valid_o,
  input  logic                       byte_ready_i,
  output logic                       last_o,
  output logic                       overflow_o,
  output logic                       error_o
);

  // One counter walks both timestamp and payload bytes.
  localparam int PAY_IDX_W = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;
  localparam int TS_IDX_W  = (TS_BYTES > 1) ? $clog2(TS_BYTES) : 1;
  localparam int IDX_W     = (PAY_IDX_W > TS_IDX_W) ? PAY_IDX_W : TS_IDX_W;
  localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1;

  typedef struct packed {
    logic                       lost;
    logic [ENC_FLOW_W-1:0]      flow;
    logic [ENC_LEN_W-1:0]       length;
    logic [PAYLOAD_BYTES*8-1:0] payload;
`ifdef TRDB_TIMESTAMP_EN
    logic [TS_BYTES*8-1:0]      ts;
`endif
  } entry_t;

  trdb_encap_state_e state_q;
  logic [IDX_W-1:0]  idx_q;
  logic              lost_q;
  entry_t            wr_entry;
  entry_t            head;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              handshake;
  logic              last_beat;
  logic              pop;
  logic              push;
  logic              len_ok;
  logic              drop_full;
  logic [7:0]        byte_d;

  assign len_ok    = (length_i != '0) && (length_i <= ENC_LEN_W'(PAYLOAD_BYTES));
  assign handshake = byte_valid_o && byte_ready_i;
  assign last_beat = (state_q == PAY) && (ENC_LEN_W'(idx_q) == head.length - 1'b1);
  assign pop       = handshake && last_beat;
  assign push      = valid_i && len_ok && (!fifo_full || pop);
  assign drop_full = valid_i && len_ok && (fifo_count == CNT_W'(FIFO_DEPTH)) && !pop;

  assign wr_entry.lost    = lost_q;
  assign wr_entry.flow    = flow_i;
  assign wr_entry.length  = length_i;
  assign wr_entry.payload = payload_i;
`ifdef TRDB_TIMESTAMP_EN
  assign wr_entry.ts      = time_i;
`endif

  trdb_encap_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push   (push),
    .wdata  (wr_entry),
    .pop    (pop),
    .rdata  (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_count)
  );

  // Select the byte for the current state from the head entry.
  always_comb begin
    byte_d = '0;
    case (state_q)
      HDR:     byte_d = make_header(head.lost, head.flow, head.length);
`ifdef TRDB_TIMESTAMP_EN
      TS:      byte_d = head.ts[{idx_q, 3'b000} +: 8];
`endif
      PAY:     byte_d = head.payload[{idx_q, 3'b000} +: 8];
      default: byte_d = '0;
    endcase
  end

  assign byte_valid_o = !fifo_empty;
  assign byte_o       = byte_valid_o ? byte_d : 8'h00;
  assign last_o       = byte_valid_o && last_beat;

  // Serialiser FSM: advances only on an accepted byte.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HDR;
      idx_q   <= '0;
    end else if (handshake) begin
      case (state_q)
        HDR: begin
          idx_q <= '0;
`ifdef TRDB_TIMESTAMP_EN
          state_q <= TS;
`else
          state_q <= PAY;
`endif
        end
`ifdef TRDB_TIMESTAMP_EN
        TS: begin
          if (idx_q == IDX_W'(TS_BYTES - 1)) begin
            idx_q   <= '0;
            state_q <= PAY;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
`endif
        PAY: begin
          if (last_beat) begin
            idx_q   <= '0;
            state_q <= HDR;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: begin
          idx_q   <= '0;
          state_q <= HDR;
        end
      endcase
    end
  end

  // Loss tracking and one-cycle drop pulses.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lost_q     <= 1'b0;
      overflow_o <= 1'b0;
      error_o    <= 1'b0;
    end else begin
      overflow_o <= drop_full;
      error_o    <= valid_i && !len_ok;
      if (push)           lost_q <= 1'b0;
      else if (drop_full) lost_q <= 1'b1;
    end
  end

endmodule
